// File: rtl/pll_seq_pkg.sv
`default_nettype none
//============================================================================
// Module      : pll_seq_pkg
// Description : Shared types and helpers for the PLL reset sequencer.
// Revision    : 1.0 - initial release
//============================================================================
package pll_seq_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABILIZE = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } seq_state_t;

   // Bits needed for a counter that must be able to hold max_val
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage : pll_seq_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
//============================================================================
// Module      : sync_2ff
// Description : 1-bit two-flop synchroniser, asynchronous active-low reset
//               clears both stages to 0.
// Revision    : 1.0 - initial release
//============================================================================
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic r_meta;

   // Two back-to-back flops; first stage may go metastable, second resolves it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         q      <= 1'b0;
      end else begin
         r_meta <= d;
         q      <= r_meta;
      end
   end

endmodule : sync_2ff
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
//============================================================================
// Module      : pll_reset_sequencer
// Description : Pulses the PLL reset, qualifies the synchronised lock flag,
//               releases the system reset after lock is stable, re-resets
//               the PLL on timeout or lock loss and latches a fail flag
//               after too many consecutive timed-out attempts.
// Revision    : 1.0 - initial release
//============================================================================
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 50000,
   parameter int STABLE_CYCLES       = 1024,
   parameter int MAX_RETRIES         = 3,
   parameter int CNT_W               = 8
) (
   input  logic                               refclk,
   input  logic                               rst_n,
   input  logic                               locked,
   input  logic                               retry_req,
   output logic                               pll_rst,
   output logic                               sys_rst_n,
   output logic                               lock_ok,
   output logic                               fail,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
   output logic [CNT_W-1:0]                   lock_loss_count
);

   localparam int PULSE_W = cnt_width(RST_PULSE_CYCLES);
   localparam int TMR_W   = cnt_width(LOCK_TIMEOUT_CYCLES);
   localparam int STB_W   = cnt_width(STABLE_CYCLES);
   localparam int RTY_W   = $clog2(MAX_RETRIES + 1);

   localparam logic [PULSE_W-1:0] C_PULSE_LAST = PULSE_W'(RST_PULSE_CYCLES - 1);
   localparam logic [TMR_W-1:0]   C_TIMEOUT    = TMR_W'(LOCK_TIMEOUT_CYCLES);
   localparam logic [STB_W-1:0]   C_STABLE     = STB_W'(STABLE_CYCLES);
   localparam logic [RTY_W-1:0]   C_MAX_RETRY  = RTY_W'(MAX_RETRIES);
   localparam logic [CNT_W-1:0]   C_LOSS_MAX   = '1;

   seq_state_t          r_state;
   seq_state_t          w_state_nxt;
   logic [PULSE_W-1:0]  r_pulse_cnt;
   logic [PULSE_W-1:0]  w_pulse_nxt;
   logic [TMR_W-1:0]    r_timer;
   logic [TMR_W-1:0]    w_timer_nxt;
   logic [TMR_W-1:0]    w_timer_inc;
   logic [STB_W-1:0]    r_stable_cnt;
   logic [STB_W-1:0]    w_stable_nxt;
   logic [STB_W-1:0]    w_stable_inc;
   logic [RTY_W-1:0]    w_retry_nxt;
   logic [RTY_W-1:0]    w_retry_inc;
   logic [CNT_W-1:0]    w_loss_nxt;
   logic                w_locked_s;
   logic                w_timeout;

   sync_2ff u_lock_sync (
      .clk   (refclk),
      .rst_n (rst_n),
      .d     (locked),
      .q     (w_locked_s)
   );

   // State register
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RESET_PLL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and counter update; the stable count includes the cycle
   // in which lock is first seen, so RUN follows STABLE_CYCLES high samples
   always_comb begin
      w_state_nxt  = r_state;
      w_pulse_nxt  = r_pulse_cnt;
      w_timer_nxt  = r_timer;
      w_stable_nxt = r_stable_cnt;
      w_retry_nxt  = retry_count;
      w_loss_nxt   = lock_loss_count;
      w_timer_inc  = r_timer + 1'b1;
      w_stable_inc = ((r_state == STABILIZE) ? r_stable_cnt : '0) + 1'b1;
      w_timeout    = (w_timer_inc == C_TIMEOUT);
      w_retry_inc  = retry_count + 1'b1;

      case (r_state)
         RESET_PLL: begin
            if (r_pulse_cnt == C_PULSE_LAST) begin
               w_state_nxt = WAIT_LOCK;
               w_pulse_nxt = '0;
               w_timer_nxt = '0;
            end else begin
               w_pulse_nxt = r_pulse_cnt + 1'b1;
            end
         end
         WAIT_LOCK, STABILIZE: begin
            // Timer is never cleared on chatter, so it bounds the whole attempt
            w_timer_nxt = w_timer_inc;
            if (w_timeout) begin
               w_retry_nxt = w_retry_inc;
               w_pulse_nxt = '0;
               w_state_nxt = (w_retry_inc == C_MAX_RETRY) ? FAIL : RESET_PLL;
            end else if (w_locked_s) begin
               if (w_stable_inc >= C_STABLE) begin
                  w_state_nxt = RUN;
                  w_retry_nxt = '0;
               end else begin
                  w_state_nxt  = STABILIZE;
                  w_stable_nxt = w_stable_inc;
               end
            end else begin
               w_state_nxt = WAIT_LOCK;
            end
         end
         RUN: begin
            if (!w_locked_s) begin
               w_state_nxt = RESET_PLL;
               w_pulse_nxt = '0;
               if (lock_loss_count != C_LOSS_MAX) begin
                  w_loss_nxt = lock_loss_count + 1'b1;
               end
            end
         end
         FAIL: begin
            if (retry_req) begin
               w_state_nxt = RESET_PLL;
               w_pulse_nxt = '0;
               w_retry_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = RESET_PLL;
            w_pulse_nxt = '0;
         end
      endcase
   end

   // Counters and outputs, decoded from the state being entered
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         r_pulse_cnt     <= '0;
         r_timer         <= '0;
         r_stable_cnt    <= '0;
         retry_count     <= '0;
         lock_loss_count <= '0;
         pll_rst         <= 1'b1;
         sys_rst_n       <= 1'b0;
         lock_ok         <= 1'b0;
         fail            <= 1'b0;
      end else begin
         r_pulse_cnt     <= w_pulse_nxt;
         r_timer         <= w_timer_nxt;
         r_stable_cnt    <= w_stable_nxt;
         retry_count     <= w_retry_nxt;
         lock_loss_count <= w_loss_nxt;
         pll_rst         <= (w_state_nxt == RESET_PLL) || (w_state_nxt == FAIL);
         sys_rst_n       <= (w_state_nxt == RUN);
         lock_ok         <= (w_state_nxt == RUN);
         fail            <= (w_state_nxt == FAIL);
      end
   end

endmodule : pll_reset_sequencer
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module      : tb_pll_reset_sequencer
// Description : Self-checking bench for pll_reset_sequencer with a
//               behavioural reference model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_pll_reset_sequencer;

   localparam int RP = 4;
   localparam int TO = 40;
   localparam int SC = 8;
   localparam int MR = 2;
   localparam int CW = 8;
   localparam int RW = $clog2(MR + 1);
   localparam int VW = 4 + RW + CW;

   logic          refclk    = 1'b0;
   logic          rst_n     = 1'b0;
   logic          locked    = 1'b0;
   logic          retry_req = 1'b0;
   logic          pll_rst;
   logic          sys_rst_n;
   logic          lock_ok;
   logic          fail;
   logic [RW-1:0] retry_count;
   logic [CW-1:0] lock_loss_count;

   int n_tests = 0;
   int n_fail  = 0;

   pll_reset_sequencer #(
      .RST_PULSE_CYCLES    (RP),
      .LOCK_TIMEOUT_CYCLES (TO),
      .STABLE_CYCLES       (SC),
      .MAX_RETRIES         (MR),
      .CNT_W               (CW)
   ) dut (
      .refclk          (refclk),
      .rst_n           (rst_n),
      .locked          (locked),
      .retry_req       (retry_req),
      .pll_rst         (pll_rst),
      .sys_rst_n       (sys_rst_n),
      .lock_ok         (lock_ok),
      .fail            (fail),
      .retry_count     (retry_count),
      .lock_loss_count (lock_loss_count)
   );

   always #5 refclk = ~refclk;

   // Reference model: a lock attempt is a pulse phase followed by a window
   // of TO cycles in which SC consecutive synchronised-lock samples win
   localparam int M_PULSE = 0, M_LOCKING = 1, M_RUN = 2, M_FAILED = 3;
   int   m_mode = M_PULSE, m_pulse = 0, m_elapsed = 0, m_streak = 0;
   int   m_retries = 0, m_losses = 0;
   logic m_d1 = 1'b0, m_d2 = 1'b0, m_ls = 1'b0;

   always @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = M_PULSE; m_pulse = 0; m_elapsed = 0; m_streak = 0;
         m_retries = 0; m_losses = 0; m_d1 = 1'b0; m_d2 = 1'b0;
      end else begin
         m_ls = m_d2; m_d2 = m_d1; m_d1 = locked;
         case (m_mode)
            M_PULSE: begin
               m_pulse++;
               if (m_pulse == RP) begin
                  m_mode = M_LOCKING; m_elapsed = 0; m_streak = 0;
               end
            end
            M_LOCKING: begin
               m_elapsed++;
               if (m_elapsed == TO) begin
                  m_retries++; m_pulse = 0;
                  m_mode = (m_retries == MR) ? M_FAILED : M_PULSE;
               end else if (m_ls) begin
                  m_streak++;
                  if (m_streak == SC) begin m_mode = M_RUN; m_retries = 0; end
               end else begin
                  m_streak = 0;
               end
            end
            M_RUN: if (!m_ls) begin
               if (m_losses < (1 << CW) - 1) m_losses++;
               m_pulse = 0; m_mode = M_PULSE;
            end
            M_FAILED: if (retry_req) begin
               m_retries = 0; m_pulse = 0; m_mode = M_PULSE;
            end
            default: ;
         endcase
      end
   end

   function automatic logic [VW-1:0] model_vec(input int mode, input int rt, input int ls);
      logic [3:0] f;
      f = {(mode == M_PULSE) || (mode == M_FAILED), mode == M_RUN, mode == M_RUN, mode == M_FAILED};
      return {f, RW'(rt), CW'(ls)};
   endfunction

   function automatic logic [VW-1:0] dut_vec();
      return {pll_rst, sys_rst_n, lock_ok, fail, retry_count, lock_loss_count};
   endfunction

   // Reset, release, and wait for the first pulse to end
   task automatic do_reset();
      int c;
      @(negedge refclk); rst_n = 1'b0; retry_req = 1'b0;
      @(negedge refclk); rst_n = 1'b1;
      c = 0;
      while (pll_rst !== 1'b0 && c < 10) begin @(negedge refclk); c++; end
      n_tests++;
      if (pll_rst !== 1'b0 || c != RP) begin
         n_fail++; $display("FAIL reset_pulse_len got=%0d exp=%0d", c, RP);
      end
   endtask

   task automatic test_reset();
      locked = 1'b0; retry_req = 1'b0; rst_n = 1'b0;
      repeat (5) @(negedge refclk);
      n_tests++;
      if ({pll_rst, sys_rst_n, lock_ok, fail} !== 4'b1000 || retry_count !== '0 || lock_loss_count !== '0) begin
         n_fail++; $display("FAIL reset_values got=%h exp=%h", dut_vec(), {4'b1000, {(RW+CW){1'b0}}});
      end
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge refclk);
         n_tests++;
         if (pll_rst !== (i < RP) || sys_rst_n !== 1'b0) begin
            n_fail++; $display("FAIL reset_release i=%0d pll_rst=%b exp=%b sys_rst_n=%b exp=0", i, pll_rst, (i < RP), sys_rst_n);
         end
         n_tests++;
         if (dut_vec() !== model_vec(m_mode, m_retries, m_losses)) begin
            n_fail++; $display("FAIL model_reset got=%h exp=%h", dut_vec(), model_vec(m_mode, m_retries, m_losses));
         end
      end
   endtask

   task automatic test_clean_lock();
      int d, c;
      for (int it = 0; it < 3; it++) begin
         locked = 1'b0; do_reset();
         d = (it == 0) ? 10 : $urandom_range(3, 15);
         repeat (d) begin
            retry_req = 1'($urandom_range(0, 1));
            @(negedge refclk); n_tests++;
            if (dut_vec() !== model_vec(m_mode, m_retries, m_losses)) begin
               n_fail++; $display("FAIL model_clean got=%h exp=%h", dut_vec(), model_vec(m_mode, m_retries, m_losses));
            end
         end
         retry_req = 1'b0; locked = 1'b1; c = 0;
         do begin
            @(negedge refclk); c++; n_tests++;
            if (dut_vec() !== model_vec(m_mode, m_retries, m_losses)) begin
               n_fail++; $display("FAIL model_clean got=%h exp=%h", dut_vec(), model_vec(m_mode, m_retries, m_losses));
            end
         end while (lock_ok !== 1'b1 && c < 30);
         n_tests++;
         if (c != 2 + SC || sys_rst_n !== 1'b1 || retry_count !== '0) begin
            n_fail++; $display("FAIL clean_lock_latency got=%0d exp=%0d sys_rst_n=%b retry=%0d", c, 2 + SC, sys_rst_n, retry_count);
         end
      end
   endtask

   task automatic test_chatter();
      int w, k, c;
      for (int it = 0; it < 3; it++) begin
         locked = 1'b0; do_reset();
         w = $urandom_range(1, 4);
         k = (it == 0) ? 5 : $urandom_range(2, SC - 1);
         repeat (w) @(negedge refclk);
         locked = 1'b1; repeat (k) @(negedge refclk);
         locked = 1'b0; @(negedge refclk);
         locked = 1'b1; c = 0;
         do begin
            @(negedge refclk); c++; n_tests++;
            if (dut_vec() !== model_vec(m_mode, m_retries, m_losses)) begin
               n_fail++; $display("FAIL model_chatter got=%h exp=%h", dut_vec(), model_vec(m_mode, m_retries, m_losses));
            end
         end while (lock_ok !== 1'b1 && c < 30);
         n_tests++;
         if (c != 2 + SC) begin
            n_fail++; $display("FAIL chatter_latency k=%0d got=%0d exp=%0d", k, c, 2 + SC);
         end
      end
   endtask

   task automatic test_timeout();
      int c, hi;
      locked = 1'b0; do_reset();
      for (int a = 1; a <= MR; a++) begin
         c = 0;
         do begin
            retry_req = 1'($urandom_range(0, 1));
            @(negedge refclk); c++;
         end while (pll_rst !== 1'b1 && c < 60);
         retry_req = 1'b0;
         n_tests++;
         if (c != TO || retry_count !== RW'(a) || fail !== (a == MR)) begin
            n_fail++; $display("FAIL timeout_%0d cycles=%0d exp=%0d retry=%0d exp=%0d fail=%b", a, c, TO, retry_count, a, fail);
         end
         n_tests++;
         if (dut_vec() !== model_vec(m_mode, m_retries, m_losses)) begin
            n_fail++; $display("FAIL model_timeout got=%h exp=%h", dut_vec(), model_vec(m_mode, m_retries, m_losses));
         end
         if (a < MR) begin
            hi = 1;
            do begin @(negedge refclk); if (pll_rst === 1'b1) hi++; end while (pll_rst === 1'b1 && hi < 20);
            n_tests++;
            if (hi != RP) begin
               n_fail++; $display("FAIL timeout_repulse got=%0d exp=%0d", hi, RP);
            end
         end
      end
      repeat ($urandom_range(5, 20)) begin
         locked = 1'($urandom_range(0, 1));
         @(negedge refclk); n_tests++;
         if (fail !== 1'b1 || pll_rst !== 1'b1 || sys_rst_n !== 1'b0 || retry_count !== RW'(MR)) begin
            n_fail++; $display("FAIL fail_hold got=%h exp fail=1 pll_rst=1 retry=%0d", dut_vec(), MR);
         end
      end
      locked = 1'b0; retry_req = 1'b1;
      @(negedge refclk); retry_req = 1'b0;
      n_tests++;
      if (fail !== 1'b0 || retry_count !== '0 || pll_rst !== 1'b1) begin
         n_fail++; $display("FAIL retry_req got fail=%b retry=%0d pll_rst=%b exp 0/0/1", fail, retry_count, pll_rst);
      end
      hi = 1;
      do begin @(negedge refclk); if (pll_rst === 1'b1) hi++; end while (pll_rst === 1'b1 && hi < 20);
      n_tests++;
      if (hi != RP) begin
         n_fail++; $display("FAIL retry_pulse got=%0d exp=%0d", hi, RP);
      end
   endtask

   task automatic test_lock_loss();
      int c;
      locked = 1'b1; do_reset();
      c = 0;
      while (lock_ok !== 1'b1 && c < 30) begin @(negedge refclk); c++; end
      repeat ($urandom_range(1, 10)) @(negedge refclk);
      locked = 1'b0; c = 0;
      do begin @(negedge refclk); c++; end while (sys_rst_n !== 1'b0 && c < 10);
      n_tests++;
      if (c != 3 || lock_loss_count !== CW'(1) || pll_rst !== 1'b1 || lock_ok !== 1'b0 || retry_count !== '0) begin
         n_fail++; $display("FAIL lock_loss edges=%0d exp=3 count=%0d exp=1 pll_rst=%b lock_ok=%b", c, lock_loss_count, pll_rst, lock_ok);
      end
      for (int it = 0; it < 300; it++) begin
         repeat ($urandom_range(0, 3)) @(negedge refclk);
         locked = 1'b1; c = 0;
         do begin
            @(negedge refclk); c++; n_tests++;
            if (dut_vec() !== model_vec(m_mode, m_retries, m_losses)) begin
               n_fail++; $display("FAIL model_loss got=%h exp=%h", dut_vec(), model_vec(m_mode, m_retries, m_losses));
            end
         end while (lock_ok !== 1'b1 && c < 40);
         n_tests++;
         if (lock_ok !== 1'b1) begin
            n_fail++; $display("FAIL loss_relock it=%0d lock_ok=%b exp=1", it, lock_ok); break;
         end
         repeat ($urandom_range(0, 3)) @(negedge refclk);
         locked = 1'b0; c = 0;
         do begin @(negedge refclk); c++; end while (sys_rst_n !== 1'b0 && c < 10);
         n_tests++;
         if (c != 3) begin
            n_fail++; $display("FAIL loss_detect it=%0d edges=%0d exp=3", it, c); break;
         end
      end
      n_tests++;
      if (lock_loss_count !== {CW{1'b1}} || m_losses != (1 << CW) - 1) begin
         n_fail++; $display("FAIL loss_saturate got=%0d exp=%0d", lock_loss_count, (1 << CW) - 1);
      end
   endtask

   task automatic test_mid_reset();
      int c;
      // Reset while in RUN with a saturated loss count
      locked = 1'b1; c = 0;
      while (lock_ok !== 1'b1 && c < 40) begin @(negedge refclk); c++; end
      repeat (2) @(posedge refclk);
      #3 rst_n = 1'b0;
      #1 n_tests++;
      if (dut_vec() !== {4'b1000, {(RW+CW){1'b0}}}) begin
         n_fail++; $display("FAIL async_reset_run got=%h exp=%h", dut_vec(), {4'b1000, {(RW+CW){1'b0}}});
      end
      @(negedge refclk); rst_n = 1'b1;
      // One loss so the count is nonzero, then reset again mid-STABILIZE
      c = 0;
      while (lock_ok !== 1'b1 && c < 40) begin @(negedge refclk); c++; end
      locked = 1'b0; c = 0;
      while (sys_rst_n !== 1'b0 && c < 10) begin @(negedge refclk); c++; end
      locked = 1'b1; c = 0;
      while (pll_rst !== 1'b0 && c < 10) begin @(negedge refclk); c++; end
      repeat (3) @(negedge refclk);
      n_tests++;
      if (lock_loss_count !== CW'(1) || lock_ok !== 1'b0 || pll_rst !== 1'b0) begin
         n_fail++; $display("FAIL pre_stab_state count=%0d exp=1 lock_ok=%b pll_rst=%b", lock_loss_count, lock_ok, pll_rst);
      end
      @(posedge refclk);
      #3 rst_n = 1'b0;
      #1 n_tests++;
      if (dut_vec() !== {4'b1000, {(RW+CW){1'b0}}}) begin
         n_fail++; $display("FAIL async_reset_stab got=%h exp=%h", dut_vec(), {4'b1000, {(RW+CW){1'b0}}});
      end
      @(negedge refclk); rst_n = 1'b1;
      repeat (3) @(negedge refclk);
      n_tests++;
      if (dut_vec() !== model_vec(m_mode, m_retries, m_losses)) begin
         n_fail++; $display("FAIL model_after_reset got=%h exp=%h", dut_vec(), model_vec(m_mode, m_retries, m_losses));
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_clean_lock();
      test_chatter();
      test_timeout();
      test_lock_loss();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_pll_reset_sequencer
`default_nettype wire
